uart_rx: RTL and testbench

//  Serial receiver paired with uart_tx: 8N1 framing, LSB first, line idles high.

---
 rtl/uart_rx_pkg.sv | 22 ++
 rtl/uart_rx_sync2.sv | 21 ++
 rtl/uart_rx.sv | 157 +++++++++++++++
 tb/tb_uart_rx.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared UART receiver definitions: divisor sizing, frame width and receiver states.
package uart_rx_pkg;

    localparam int UART_DIV_W       = 13;
    localparam int UART_DEFAULT_DIV = 3125;
    localparam int UART_MIN_DIV     = 4;
    localparam int UART_DATA_W      = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BRK
    } rx_state_t;

    function automatic logic even_parity(input logic [UART_DATA_W-1:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/uart_rx_sync2.sv
// Two-flop synchroniser for the asynchronous rx line; resets to the idle (high) level.
module uart_rx_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with runtime divisor and mid-bit sampling.
// Define UART_RX_PARITY_EN for 8E1 framing with a parity_err strobe.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int DEFAULT_DIV = UART_DEFAULT_DIV,
    parameter int DIV_W       = UART_DIV_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rx,
    input  logic                   set,
    input  logic [DIV_W-1:0]       div_in,
    output logic [UART_DATA_W-1:0] data,
    output logic                   valid,
    output logic                   busy,
    output logic                   frame_err,
    output logic                   parity_err
);

    localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(UART_MIN_DIV);

    rx_state_t              state;
    logic                   rx_s;
    logic                   rx_s_d;
    logic [DIV_W-1:0]       div;
    logic [DIV_W-1:0]       cnt;
    logic [2:0]             bit_idx;
    logic [UART_DATA_W-1:0] shreg;
    logic                   set_ok;
    logic [DIV_W-1:0]       div_now;
    logic                   cnt_zero;

    uart_rx_sync2 u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    // A divisor written in the same cycle as a start edge already governs that frame.
    assign set_ok   = set && (state == ST_IDLE) && (div_in >= DIV_MIN);
    assign div_now  = set_ok ? div_in : div;
    assign cnt_zero = (cnt == '0);
    assign busy     = (state != ST_IDLE);

`ifdef UART_RX_PARITY_EN
    logic par_bit;
    logic par_bad;
    assign par_bad = (even_parity(shreg) != par_bit);
`else
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            div       <= DIV_RST;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            rx_s_d    <= 1'b1;
`ifdef UART_RX_PARITY_EN
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
            rx_s_d    <= rx_s;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            if (set_ok)
                div <= div_in;

            case (state)
                ST_IDLE: begin
                    if (rx_s_d && !rx_s) begin
                        state <= ST_START;
                        cnt   <= div_now >> 1;
                    end
                end
                ST_START: begin
                    if (!cnt_zero) begin
                        cnt <= cnt - 1'b1;
                    end else if (!rx_s) begin
                        state   <= ST_DATA;
                        cnt     <= div - 1'b1;
                        bit_idx <= '0;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_DATA: begin
                    if (!cnt_zero) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        shreg   <= {rx_s, shreg[UART_DATA_W-1:1]};
                        cnt     <= div - 1'b1;
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= ST_PARITY;
`else
                            state <= ST_STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (!cnt_zero) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        par_bit <= rx_s;
                        cnt     <= div - 1'b1;
                        state   <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (!cnt_zero) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        data <= shreg;
`ifdef UART_RX_PARITY_EN
                        parity_err <= par_bad;
`endif
                        if (rx_s) begin
`ifdef UART_RX_PARITY_EN
                            valid <= !par_bad;
`else
                            valid <= 1'b1;
`endif
                            state <= ST_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= ST_BRK;
                        end
                    end
                end
                // A stuck-low line must go high before another start edge can be seen.
                ST_BRK: begin
                    if (rx_s)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed plus randomized bench for uart_rx; frames are built bit by bit and
// expected bytes/strobe times come from the line-level timing rules.
module tb_uart_rx;

`ifdef UART_RX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx = 1'b1;
    logic        set = 1'b0;
    logic [12:0] div_in = '0;
    logic [7:0]  data;
    logic        valid;
    logic        busy;
    logic        frame_err;
    logic        parity_err;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int cur_div;
    logic [7:0] vq_data[$];
    int vq_cyc[$];
    int fe_cnt = 0;
    int pe_cnt = 0;
    int pe_total = 0;

    uart_rx dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .set        (set),
        .div_in     (div_in),
        .data       (data),
        .valid      (valid),
        .busy       (busy),
        .frame_err  (frame_err),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid) begin
            vq_data.push_back(data);
            vq_cyc.push_back(cyc);
        end
        if (frame_err) fe_cnt++;
        if (parity_err) begin
            pe_cnt++;
            pe_total++;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time %0t exceeded, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_win(input string tag, input int obs, input int lo, input int hi);
        n_cmp++;
        assert (obs >= lo && obs <= hi) else begin
            n_bad++;
            $error("FAIL %s: observed cycle %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_mon();
        vq_data.delete();
        vq_cyc.delete();
        fe_cnt = 0;
        pe_cnt = 0;
    endtask

    // Idle-time divisor write; the model keeps the old value for anything below 4.
    task automatic do_set(input int val);
        set = 1'b1;
        div_in = val[12:0];
        tick(1);
        set = 1'b0;
        if (val >= 4) cur_div = val;
    endtask

    // act: 0 none, 1 pulse set with act_val at bit act_bit, 2 reset pulse at act_bit and abort.
    task automatic send_frame(input logic [7:0] b, input logic stop_lvl, input logic par_flip,
                              input int d, input int act, input int act_bit, input int act_val,
                              output int fall);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(b[i]);
        if (PAR) bits.push_back((^b) ^ par_flip);
        bits.push_back(stop_lvl);
        fall = cyc + 1;
        foreach (bits[i]) begin
            rx = bits[i];
            if (act == 1 && i == act_bit) begin
                set = 1'b1;
                div_in = act_val[12:0];
            end
            if (act == 2 && i == act_bit) begin
                reset = 1'b1;
                tick(1);
                reset = 1'b0;
                rx = 1'b1;
                return;
            end
            tick(1);
            set = 1'b0;
            tick(d - 1);
        end
    endtask

    function automatic int exp_lo(input int fall, input int d);
        return fall + 2 + d / 2 + 9 * d + (PAR ? d : 0);
    endfunction

    task automatic check_frame(input string tag, input logic [7:0] b, input int fall, input int d);
        check({tag, "_nvalid"}, vq_data.size(), 1);
        if (vq_data.size() > 0) begin
            check({tag, "_data"}, vq_data[0], b);
            check_win({tag, "_time"}, vq_cyc[0], exp_lo(fall, d), exp_lo(fall, d) + 1);
        end
        check({tag, "_ferr"}, fe_cnt, 0);
    endtask

    initial begin
        int f;
        int f2;
        int val;
        int gap;
        logic [7:0] b;

        cur_div = 3125;
        tick(3);
        reset = 1'b0;
        check("rst_data", data, 8'h00);
        check("rst_valid", valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ferr", frame_err, 1'b0);
        check("rst_perr", parity_err, 1'b0);

        // Basic frame at 16 clk/bit
        do_set(16);
        tick(2);
        clear_mon();
        send_frame(8'hA5, 1'b1, 1'b0, cur_div, 0, 0, 0, f);
        tick(4);
        check_frame("a5", 8'hA5, f, cur_div);

        // False start: 5 clk low pulse
        clear_mon();
        rx = 1'b0;
        f = cyc + 1;
        tick(5);
        rx = 1'b1;
        check("fs_busy_mid", busy, 1'b1);
        tick(8);
        check("fs_busy_end", busy, 1'b0);
        tick(20);
        check("fs_nvalid", vq_data.size(), 0);
        check("fs_ferr", fe_cnt, 0);

        // Stop bit low, line stuck low 40 clk
        clear_mon();
        send_frame(8'h3C, 1'b0, 1'b0, cur_div, 0, 0, 0, f);
        tick(24);
        check("fe_pulses", fe_cnt, 1);
        check("fe_data", data, 8'h3C);
        check("fe_nvalid", vq_data.size(), 0);
        check("fe_busy_low", busy, 1'b1);
        rx = 1'b1;
        tick(4);
        check("fe_busy_rel", busy, 1'b0);

        // Back-to-back frames with no idle gap
        clear_mon();
        send_frame(8'h00, 1'b1, 1'b0, cur_div, 0, 0, 0, f);
        send_frame(8'hFF, 1'b1, 1'b0, cur_div, 0, 0, 0, f2);
        tick(4);
        check("b2b_nvalid", vq_data.size(), 2);
        if (vq_data.size() == 2) begin
            check("b2b_d0", vq_data[0], 8'h00);
            check("b2b_d1", vq_data[1], 8'hFF);
            check("b2b_gap", vq_cyc[1] - vq_cyc[0], 10 * cur_div + (PAR ? cur_div : 0));
            check_win("b2b_t0", vq_cyc[0], exp_lo(f, cur_div), exp_lo(f, cur_div) + 1);
        end
        check("b2b_ferr", fe_cnt, 0);

        // set while busy is ignored
        clear_mon();
        send_frame(8'h5A, 1'b1, 1'b0, cur_div, 1, 3, 8, f);
        tick(4);
        check_frame("setbusy", 8'h5A, f, cur_div);

        // set below minimum is ignored
        do_set(3);
        tick(2);
        clear_mon();
        send_frame(8'hC3, 1'b1, 1'b0, cur_div, 0, 0, 0, f);
        tick(4);
        check_frame("setmin", 8'hC3, f, cur_div);

        // Randomized bytes, divisors and idle gaps
        for (int k = 0; k < 12; k++) begin
            val = $urandom_range(2, 24);
            do_set(val);
            gap = $urandom_range(0, 2 * cur_div);
            tick(gap + 1);
            clear_mon();
            b = 8'($urandom);
            send_frame(b, 1'b1, 1'b0, cur_div, 0, 0, 0, f);
            tick(4);
            check_frame($sformatf("rnd%0d", k), b, f, cur_div);
        end

        // Reset mid-frame at data bit 4, then a frame at the reset divisor
        do_set(16);
        tick(2);
        clear_mon();
        send_frame(8'h55, 1'b1, 1'b0, cur_div, 2, 5, 0, f);
        cur_div = 3125;
        check("rstmid_busy", busy, 1'b0);
        check("rstmid_data", data, 8'h00);
        tick(40);
        check("rstmid_nvalid", vq_data.size(), 0);
        check("rstmid_ferr", fe_cnt, 0);
        clear_mon();
        send_frame(8'h81, 1'b1, 1'b0, cur_div, 0, 0, 0, f);
        tick(4);
        check_frame("after_rst", 8'h81, f, cur_div);

`ifdef UART_RX_PARITY_EN
        do_set(16);
        tick(2);
        clear_mon();
        send_frame(8'h07, 1'b1, 1'b1, cur_div, 0, 0, 0, f);
        tick(4);
        check("par_pulses", pe_cnt, 1);
        check("par_nvalid", vq_data.size(), 0);
        check("par_data", data, 8'h07);
        check("par_ferr", fe_cnt, 0);
`endif
        check("perr_total", pe_total, PAR ? 1 : 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
